// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage PC/request controller: one outstanding instruction-bus read, 3 cycles per fetch on a zero-wait bus.
// Decode back-pressure (stallF) holds the presented instruction; redirects squash in-flight responses.
module inst_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [31:0] pc_next,
   input  logic        redirectM,
   input  logic        stallF,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata,
   output logic [31:0] pcF,
   output logic [31:0] pc_plus4F,
   output logic [31:0] instrF,
   output logic        instr_validF,
   output logic        adelF,
   output logic        fetch_busy
);

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_DISCARD
   } state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        adel_q, adel_d;
   logic        pc_misal;

   assign pc_misal = (pc_q[1:0] != 2'b00);

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      adel_d  = adel_q;
      case (state_q)
         S_BOOT: begin
            state_d = S_REQ;
         end
         S_REQ: begin
            // A misaligned PC never reaches the bus; it is reported straight to decode.
            if (pc_misal) begin
               instr_d = 32'h0;
               adel_d  = 1'b1;
               state_d = S_HOLD;
            end else if (redirectM) begin
               pc_d    = pc_next;
               state_d = inst_addr_ok ? S_DISCARD : S_REQ;
            end else if (inst_addr_ok) begin
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirectM) begin
               pc_d    = pc_next;
               state_d = inst_data_ok ? S_REQ : S_DISCARD;
            end else if (inst_data_ok) begin
               instr_d = inst_rdata;
               adel_d  = 1'b0;
               state_d = S_HOLD;
            end
         end
         S_DISCARD: begin
            if (redirectM) begin
               pc_d = pc_next;
            end
            if (inst_data_ok) begin
               state_d = S_REQ;
            end
         end
         S_HOLD: begin
            if (redirectM || !stallF) begin
               pc_d    = pc_next;
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_BOOT;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= S_BOOT;
         pc_q    <= RESET_PC;
         instr_q <= 32'h0;
         adel_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         adel_q  <= adel_d;
      end
   end

   assign inst_req     = (state_q == S_REQ) && !pc_misal;
   assign inst_addr    = pc_q;
   assign pcF          = pc_q;
   assign pc_plus4F    = pc_q + 32'd4;
   assign instrF       = instr_q;
   assign adelF        = adel_q;
   assign instr_validF = (state_q == S_HOLD);
   assign fetch_busy   = (state_q == S_WAIT) || (state_q == S_DISCARD);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: scripted bus responses, scoreboard of instructions expected at decode.
module tb_inst_fetch_ctrl;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic        adel;
   } exp_t;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] pc_next;
   logic        redirectM;
   logic        stallF;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;
   logic [31:0] pcF;
   logic [31:0] pc_plus4F;
   logic [31:0] instrF;
   logic        instr_validF;
   logic        adelF;
   logic        fetch_busy;

   int   checks = 0;
   int   passes = 0;
   exp_t sb[$];
   logic prev_valid = 1'b0;

   inst_fetch_ctrl #(.RESET_PC(32'hBFC0_0000)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .pc_next      (pc_next),
      .redirectM    (redirectM),
      .stallF       (stallF),
      .inst_req     (inst_req),
      .inst_addr    (inst_addr),
      .inst_addr_ok (inst_addr_ok),
      .inst_data_ok (inst_data_ok),
      .inst_rdata   (inst_rdata),
      .pcF          (pcF),
      .pc_plus4F    (pc_plus4F),
      .instrF       (instrF),
      .instr_validF (instr_validF),
      .adelF        (adelF),
      .fetch_busy   (fetch_busy)
   );

   always #5 clk = ~clk;

   // Each instruction presented to decode is compared once, on the cycle it first appears.
   always @(negedge clk) begin
      if (instr_validF && !prev_valid) begin
         checks++;
         if (sb.size() == 0) begin
            $display("FAIL sb_unexpected: got pc=%h instr=%h adel=%b, required no instruction", pcF, instrF, adelF);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if ({pcF, instrF, adelF} !== {e.pc, e.instr, e.adel})
               $display("FAIL sb_instr: got pc=%h instr=%h adel=%b, required pc=%h instr=%h adel=%b",
                        pcF, instrF, adelF, e.pc, e.instr, e.adel);
            else
               passes++;
         end
      end
      prev_valid = instr_validF;
   end

   task automatic step;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset;
      resetn = 1'b0; pc_next = 32'h0; redirectM = 1'b0; stallF = 1'b0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = 32'h0;
      step(); step();
      checks++;
      if ({pcF, instrF, adelF, inst_req, instr_validF, fetch_busy} !== {32'hBFC00000, 32'h0, 4'b0000})
         $display("FAIL reset_state: got pc=%h instr=%h adel=%b req=%b vld=%b busy=%b, required pc=bfc00000 all else 0",
                  pcF, instrF, adelF, inst_req, instr_validF, fetch_busy);
      else passes++;
      resetn = 1'b1;
      checks++;
      if (inst_req !== 1'b0)
         $display("FAIL boot_no_req: got req=%b, required 0", inst_req);
      else passes++;
      step();
   endtask

   task automatic test_basic_fetch;
      checks++;
      if ({inst_req, inst_addr} !== {1'b1, 32'hBFC00000})
         $display("FAIL first_req: got req=%b addr=%h, required req=1 addr=bfc00000", inst_req, inst_addr);
      else passes++;
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      checks++;
      if ({inst_req, fetch_busy} !== 2'b01)
         $display("FAIL wait_state: got req=%b busy=%b, required req=0 busy=1", inst_req, fetch_busy);
      else passes++;
      inst_data_ok = 1'b1; inst_rdata = 32'h24080001;
      sb.push_back('{pc: 32'hBFC00000, instr: 32'h24080001, adel: 1'b0});
      step();
      inst_data_ok = 1'b0; inst_rdata = 32'h0;
      checks++;
      if ({instr_validF, instrF, pcF, pc_plus4F, fetch_busy} !== {1'b1, 32'h24080001, 32'hBFC00000, 32'hBFC00004, 1'b0})
         $display("FAIL basic_hold: got vld=%b instr=%h pc=%h pc4=%h busy=%b, required 1 24080001 bfc00000 bfc00004 0",
                  instr_validF, instrF, pcF, pc_plus4F, fetch_busy);
      else passes++;
   endtask

   task automatic test_stall;
      stallF = 1'b1; pc_next = 32'hDEADBEE0;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if ({instr_validF, instrF, pcF, inst_req} !== {1'b1, 32'h24080001, 32'hBFC00000, 1'b0})
            $display("FAIL stall_hold_%0d: got vld=%b instr=%h pc=%h req=%b, required 1 24080001 bfc00000 0",
                     i, instr_validF, instrF, pcF, inst_req);
         else passes++;
      end
      stallF = 1'b0; pc_next = 32'hBFC00004;
      step();
      pc_next = 32'h0BAD0BAD;
      checks++;
      if ({inst_req, inst_addr, instr_validF} !== {1'b1, 32'hBFC00004, 1'b0})
         $display("FAIL stall_release: got req=%b addr=%h vld=%b, required req=1 addr=bfc00004 vld=0",
                  inst_req, inst_addr, instr_validF);
      else passes++;
   endtask

   task automatic test_redirect_wait;
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0; redirectM = 1'b1; pc_next = 32'h80001000;
      step();
      redirectM = 1'b0; pc_next = 32'h0BAD0BAD;
      checks++;
      if ({fetch_busy, inst_req, instr_validF, pcF} !== {3'b100, 32'h80001000})
         $display("FAIL discard_state: got busy=%b req=%b vld=%b pc=%h, required 1 0 0 80001000",
                  fetch_busy, inst_req, instr_validF, pcF);
      else passes++;
      step();
      inst_data_ok = 1'b1; inst_rdata = 32'hFFFF0000;
      step();
      inst_data_ok = 1'b0;
      checks++;
      if ({inst_req, inst_addr, instr_validF, fetch_busy} !== {1'b1, 32'h80001000, 2'b00})
         $display("FAIL redirect_wait_req: got req=%b addr=%h vld=%b busy=%b, required 1 80001000 0 0",
                  inst_req, inst_addr, instr_validF, fetch_busy);
      else passes++;
   endtask

   task automatic test_redirect_with_data;
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      redirectM = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h11111111; pc_next = 32'h80002000;
      step();
      redirectM = 1'b0; inst_data_ok = 1'b0;
      checks++;
      if ({inst_req, inst_addr, instr_validF} !== {1'b1, 32'h80002000, 1'b0})
         $display("FAIL redirect_data_req: got req=%b addr=%h vld=%b, required 1 80002000 0",
                  inst_req, inst_addr, instr_validF);
      else passes++;
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h8C090004;
      sb.push_back('{pc: 32'h80002000, instr: 32'h8C090004, adel: 1'b0});
      step();
      inst_data_ok = 1'b0; pc_next = 32'h80002004;
      step();
   endtask

   task automatic test_misaligned;
      redirectM = 1'b1; pc_next = 32'h80000002;
      sb.push_back('{pc: 32'h80000002, instr: 32'h0, adel: 1'b1});
      step();
      redirectM = 1'b0;
      checks++;
      if ({inst_req, fetch_busy, pcF} !== {2'b00, 32'h80000002})
         $display("FAIL misal_no_req: got req=%b busy=%b pc=%h, required 0 0 80000002", inst_req, fetch_busy, pcF);
      else passes++;
      step();
      checks++;
      if ({instr_validF, adelF, instrF, pcF, inst_req} !== {2'b11, 32'h0, 32'h80000002, 1'b0})
         $display("FAIL misal_adel: got vld=%b adel=%b instr=%h pc=%h req=%b, required 1 1 00000000 80000002 0",
                  instr_validF, adelF, instrF, pcF, inst_req);
      else passes++;
      pc_next = 32'hFFFFFFFC;
      step();
      checks++;
      if ({pcF, pc_plus4F, inst_req} !== {32'hFFFFFFFC, 32'h0, 1'b1})
         $display("FAIL pc_wrap: got pc=%h pc4=%h req=%b, required fffffffc 00000000 1", pcF, pc_plus4F, inst_req);
      else passes++;
   endtask

   task automatic test_reset_mid;
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0;
      resetn = 1'b0;
      #1;
      checks++;
      if ({pcF, fetch_busy, inst_req, instr_validF} !== {32'hBFC00000, 3'b000})
         $display("FAIL async_reset: got pc=%h busy=%b req=%b vld=%b, required bfc00000 0 0 0",
                  pcF, fetch_busy, inst_req, instr_validF);
      else passes++;
      step();
      resetn = 1'b1; inst_data_ok = 1'b1; inst_rdata = 32'h22222222;
      step();
      inst_data_ok = 1'b0;
      checks++;
      if ({inst_req, inst_addr, instr_validF, fetch_busy} !== {1'b1, 32'hBFC00000, 2'b00})
         $display("FAIL reset_stale_drop: got req=%b addr=%h vld=%b busy=%b, required 1 bfc00000 0 0",
                  inst_req, inst_addr, instr_validF, fetch_busy);
      else passes++;
      inst_addr_ok = 1'b1;
      step();
      inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h3C1DBFC0;
      sb.push_back('{pc: 32'hBFC00000, instr: 32'h3C1DBFC0, adel: 1'b0});
      step();
      inst_data_ok = 1'b0;
      step();
      checks++;
      if (sb.size() != 0)
         $display("FAIL sb_leftover: got %0d undelivered instructions, required 0", sb.size());
      else passes++;
   endtask

   initial begin
      test_reset();
      test_basic_fetch();
      test_stall();
      test_redirect_wait();
      test_redirect_with_data();
      test_misaligned();
      test_reset_mid();
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/inst_fetch_ctrl.md
# inst_fetch_ctrl

Fetch-stage controller sitting directly downstream of the next-PC selector. It holds the architectural fetch PC and loads the selected next PC from that selector. It issues instruction fetches on the SRAM-like instruction bus, with one request outstanding at most. It presents the fetched instruction to decode, handling decode back-pressure, mid-flight redirects (exception, jr, jump, branch) and misaligned-PC address errors.

## Interface
Parameters:
- RESET_PC, 32'hBFC0_0000, fetch address after reset

Ports:
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous, active-low reset
- pc_next  in  32  selected next PC from the next-PC selector
- redirectM  in  1  pc_next is non-sequential; squash the in-flight fetch
- stallF  in  1  decode cannot accept the presented instruction
- inst_req  out  1  fetch request
- inst_addr  out  32  fetch address, equal to pcF
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data valid this cycle
- inst_rdata  in  32  read data
- pcF  out  32  current fetch PC
- pc_plus4F  out  32  pcF + 4, fed back to the next-PC selector
- instrF  out  32  fetched instruction
- instr_validF  out  1  instrF/adelF valid for decode
- adelF  out  1  pcF misaligned (pcF[1:0] != 0)
- fetch_busy  out  1  bus transaction outstanding (state WAIT or DISCARD)

## Operation
- States: BOOT, REQ, WAIT, HOLD, DISCARD. Registered outputs: pc_r (drives pcF/inst_addr), instrF, adelF.
- pc_plus4F = pc_r + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- BOOT: the state after reset. Next cycle goes to REQ. inst_data_ok is ignored here, so stale responses from before reset are dropped.
- REQ, pc_r aligned: inst_req=1.
  - redirectM with no inst_addr_ok: pc_r<=pc_next, stay in REQ. Changing the address of an unaccepted request is legal.
  - inst_addr_ok with no redirectM: go to WAIT.
  - inst_addr_ok and redirectM together: pc_r<=pc_next, go to DISCARD.
- REQ, pc_r misaligned: inst_req=0, instrF<=0, adelF<=1, go to HOLD. No bus transaction is made.
- WAIT:
  - inst_data_ok, no redirectM: instrF<=inst_rdata, adelF<=0, go to HOLD.
  - redirectM without inst_data_ok: pc_r<=pc_next, go to DISCARD.
  - redirectM with inst_data_ok: data dropped, pc_r<=pc_next, go to REQ.
- DISCARD: waits for the squashed response.
  - inst_data_ok: data dropped, go to REQ.
  - redirectM: pc_r<=pc_next. Stay in DISCARD, or go to REQ if inst_data_ok arrives in the same cycle.
- HOLD: instr_validF=1.
  - redirectM: instruction squashed, pc_r<=pc_next, go to REQ. redirectM has priority over stallF.
  - !stallF: instruction consumed, pc_r<=pc_next, go to REQ.
  - stallF: hold instrF, adelF and pc_r stable.
- instr_validF=1 only in HOLD. inst_req=1 only in REQ with an aligned pc_r.

## Timing
- Reset (resetn low, asynchronous): state=BOOT, pc_r=RESET_PC, instrF=0, adelF=0, inst_req=0, instr_validF=0, fetch_busy=0.
- First request: cycle 1 after resetn deasserts (BOOT lasts one cycle).
- Zero-wait bus: request accepted at cycle t, data at t+1, instr_validF at t+2, next request at t+3 if stallF is low at t+2. Throughput is 1 instruction per 3 cycles; the block is not pipelined.
- Misaligned PC: instr_validF with adelF=1 asserts in the cycle after REQ.
- pc_next is sampled only on the load edges defined in Operation and is otherwise ignored.
- At most one outstanding transaction. A new inst_req is never raised while a response is pending (WAIT/DISCARD).
- resetn asserted mid-transaction: immediate return to reset values, with no further bus activity until BOOT exits.

## Test plan
- Reset release, addr_ok at once, data_ok next cycle with 0x24080001 -> inst_addr=0xBFC00000, then instr_validF=1, instrF=0x24080001, pcF=0xBFC00000, pc_plus4F=0xBFC00004.
- stallF held 3 cycles in HOLD, with pc_next=0xBFC00004 on release -> instrF stable and inst_req=0 throughout; one cycle after release inst_req=1 with inst_addr=0xBFC00004.
- redirectM in WAIT with pc_next=0x80001000, stale data_ok 2 cycles later -> instr_validF never asserts; the next request is to 0x80001000.
- redirectM coincident with data_ok in WAIT, pc_next=0x80002000 -> data dropped, REQ to 0x80002000 the following cycle.
- redirectM to 0x80000002 -> inst_req stays 0; next cycle instr_validF=1, adelF=1, instrF=0, pcF=0x80000002.
- pc_r=0xFFFFFFFC -> pc_plus4F=0x00000000. resetn pulsed low during WAIT, late data_ok in BOOT -> ignored; request to 0xBFC00000.
